sprite_renderer: RTL and testbench

Per-pixel sprite overlay stage placed directly downstream of the sprite table. It holds one sprite's screen position and table index, drives the table's `sprite_index` input, and converts the returned 16x16 array of 3-bit colour indices into a per-pixel colour stream aligned with the VGA scan position. Position and index updates arrive through a valid/ready request port and become active only at frame start, so a sprite never tears mid-frame. Colour index 7 marks a transparent pixel.

---
 rtl/sprite_renderer.sv | 120 ++++++++++++
 tb/tb_sprite_renderer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// Single-sprite overlay stage: latches position/index requests, commits them at frame
// start, and turns the sprite table's 16x16 colour indices into a 2-cycle pixel stream.
module sprite_renderer #(
    parameter int         SPR_W       = 16,
    parameter logic [2:0] TRANSPARENT = 3'd7
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic                              frame_start,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [9:0]                        req_x,
    input  logic [9:0]                        req_y,
    input  logic [2:0]                        req_index,
    input  logic                              req_show,
    output logic [2:0]                        sprite_index,
    input  logic [SPR_W-1:0][SPR_W-1:0][2:0]  sprite,
    input  logic [9:0]                        DrawX,
    input  logic [9:0]                        DrawY,
    output logic                              pix_opaque,
    output logic [2:0]                        pix_color
);

    // state | meaning
    // IDLE  | ready for a request; active set displayed unchanged
    // PEND  | shadow holds a request waiting for the next frame_start
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        load_sh, commit;

    logic [9:0]  sh_x_q, sh_y_q, act_x_q, act_y_q;
    logic [2:0]  sh_idx_q, act_idx_q;
    logic        sh_show_q, act_show_q;

    logic [10:0] dx_d, dy_d;
    logic [3:0]  dx_q, dy_q, col;
    logic        hit_d1, hit_q, hit2_q;
    logic [2:0]  c_q;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        load_sh   = 1'b0;
        commit    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                // frame_start here is ignored even if a request lands in the same cycle
                if (req_valid) begin
                    load_sh = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (frame_start) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_idx_q   <= '0;
            sh_show_q  <= 1'b0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            act_idx_q  <= '0;
            act_show_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_sh) begin
                sh_x_q    <= req_x;
                sh_y_q    <= req_y;
                sh_idx_q  <= req_index;
                sh_show_q <= req_show;
            end
            if (commit) begin
                act_x_q    <= sh_x_q;
                act_y_q    <= sh_y_q;
                act_idx_q  <= sh_idx_q;
                act_show_q <= sh_show_q;
            end
        end
    end

    assign sprite_index = act_idx_q;

    // Zero-extended 11-bit subtraction: a negative offset sets bit 10, so no wrap-around.
    assign dx_d   = {1'b0, DrawX} - {1'b0, act_x_q};
    assign dy_d   = {1'b0, DrawY} - {1'b0, act_y_q};
    assign hit_d1 = act_show_q && (dx_d < 11'(SPR_W)) && (dy_d < 11'(SPR_W));
    assign col    = 4'(SPR_W - 1) - dx_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dx_q   <= '0;
            dy_q   <= '0;
            hit_q  <= 1'b0;
            c_q    <= '0;
            hit2_q <= 1'b0;
        end else begin
            dx_q   <= dx_d[3:0];
            dy_q   <= dy_d[3:0];
            hit_q  <= hit_d1;
            c_q    <= sprite[dy_q][col];
            hit2_q <= hit_q;
        end
    end

    assign pix_opaque = hit2_q && (c_q != TRANSPARENT);
    assign pix_color  = pix_opaque ? c_q : 3'd0;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: request/commit handshake and pixel overlay output.
module tb_sprite_renderer;

    logic                       Clk = 1'b0;
    logic                       Reset_n;
    logic                       frame_start, req_valid, req_ready, req_show;
    logic [9:0]                 req_x, req_y, DrawX, DrawY;
    logic [2:0]                 req_index, sprite_index, pix_color;
    logic                       pix_opaque;
    logic [15:0][15:0][2:0]     sprite;

    int checks = 0;
    int failures = 0;

    // Model of what the active set should currently hold
    int m_x, m_y, m_idx, m_show;

    sprite_renderer dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_index(req_index), .req_show(req_show),
        .sprite_index(sprite_index), .sprite(sprite),
        .DrawX(DrawX), .DrawY(DrawY),
        .pix_opaque(pix_opaque), .pix_color(pix_color)
    );

    always #5 Clk = ~Clk;

    function automatic logic [2:0] tbl(input int idx, input int row, input int bitn);
        if (idx == 0 && row == 0 && bitn == 15) return 3'd7;
        if (idx == 0 && row == 0 && bitn == 10) return 3'd3;
        return 3'((row * 3 + bitn * 5 + idx) & 7);
    endfunction

    always_comb begin
        sprite = '0;
        for (int r = 0; r < 16; r++)
            for (int b = 0; b < 16; b++)
                sprite[r][b] = tbl(int'(sprite_index), r, b);
    end

    task automatic exp_pixel(input int x, input int y, output logic op, output logic [2:0] col);
        int dx, dy;
        logic [2:0] c;
        dx = x - m_x;
        dy = y - m_y;
        op = 1'b0;
        col = 3'd0;
        if (m_show != 0 && dx >= 0 && dx <= 15 && dy >= 0 && dy <= 15) begin
            c = tbl(m_idx, dy, 15 - dx);
            if (c != 3'd7) begin
                op = 1'b1;
                col = c;
            end
        end
    endtask

    task automatic pix(input int x, input int y, input string nm);
        logic eo;
        logic [2:0] ec;
        exp_pixel(x, y, eo, ec);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checks++;
        if (pix_opaque !== eo || pix_color !== ec) begin
            failures++;
            $display("FAIL %s (%0d,%0d): opaque=%b color=%0d required opaque=%b color=%0d",
                     nm, x, y, pix_opaque, pix_color, eo, ec);
        end
    endtask

    task automatic do_req(input int x, input int y, input int idx, input int show);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge Clk);
            #1;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_wait: req_ready=%b required 1 within 20 cycles", req_ready);
        end
        req_x = 10'(x); req_y = 10'(y); req_index = 3'(idx); req_show = 1'(show);
        req_valid = 1'b1;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        frame_start = 0; req_valid = 0; req_x = 0; req_y = 0; req_index = 0; req_show = 0;
        DrawX = 0; DrawY = 0;
        m_x = 0; m_y = 0; m_idx = 0; m_show = 0;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        chk("reset_ready", 10'(req_ready), 10'd1);
        chk("reset_index", 10'(sprite_index), 10'd0);
        chk("reset_opaque", 10'(pix_opaque), 10'd0);
        chk("reset_color", 10'(pix_color), 10'd0);
        for (int i = 0; i < 6; i++) pix(i * 3, i, "idle_scan");
        chk("idle_ready", 10'(req_ready), 10'd1);
    endtask

    task automatic test_basic();
        logic eo;
        logic [2:0] ec;
        do_req(100, 50, 0, 1);
        chk("basic_ready_low", 10'(req_ready), 10'd0);
        pulse_frame();
        m_x = 100; m_y = 50; m_idx = 0; m_show = 1;
        chk("basic_ready_back", 10'(req_ready), 10'd1);
        chk("basic_index", 10'(sprite_index), 10'd0);
        // Hand-computed spec points
        DrawX = 100; DrawY = 50;
        @(posedge Clk); @(posedge Clk); #1;
        chk("basic_100_50_op", 10'(pix_opaque), 10'd0);
        DrawX = 105; DrawY = 50;
        @(posedge Clk); @(posedge Clk); #1;
        chk("basic_105_50_op", 10'(pix_opaque), 10'd1);
        chk("basic_105_50_col", 10'(pix_color), 10'd3);
        DrawX = 116; DrawY = 50;
        @(posedge Clk); @(posedge Clk); #1;
        chk("basic_116_50_op", 10'(pix_opaque), 10'd0);
        pix(99, 50, "basic_left");
        pix(100, 49, "basic_above");
        pix(115, 65, "basic_corner");
        pix(100, 66, "basic_below");
        pix(107, 58, "basic_mid");
        exp_pixel(115, 65, eo, ec);
    endtask

    task automatic test_back_to_back();
        do_req(200, 100, 2, 1);
        req_x = 300; req_y = 200; req_index = 5; req_show = 1;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
            #1;
            chk("b2b_ready_held", 10'(req_ready), 10'd0);
            chk("b2b_index_old", 10'(sprite_index), 10'd0);
        end
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        frame_start = 1'b0;
        chk("b2b_commit_index", 10'(sprite_index), 10'd2);
        chk("b2b_ready_after", 10'(req_ready), 10'd1);
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_second_taken", 10'(req_ready), 10'd0);
        chk("b2b_active_first", 10'(sprite_index), 10'd2);
        m_x = 200; m_y = 100; m_idx = 2; m_show = 1;
        pix(200, 100, "b2b_pix_a");
        pix(215, 115, "b2b_pix_b");
        pix(300, 200, "b2b_pix_notyet");
        pulse_frame();
        m_x = 300; m_y = 200; m_idx = 5; m_show = 1;
        chk("b2b_second_commit", 10'(sprite_index), 10'd5);
        pix(303, 201, "b2b_pix_c");
    endtask

    task automatic test_same_cycle();
        req_x = 10; req_y = 10; req_index = 3; req_show = 1;
        req_valid = 1'b1;
        frame_start = 1'b1;
        @(posedge Clk);
        #1;
        req_valid = 1'b0;
        frame_start = 1'b0;
        chk("same_no_commit", 10'(sprite_index), 10'd5);
        chk("same_captured", 10'(req_ready), 10'd0);
        pix(303, 201, "same_old_pix");
        pulse_frame();
        m_x = 10; m_y = 10; m_idx = 3; m_show = 1;
        chk("same_commit_next", 10'(sprite_index), 10'd3);
        chk("same_ready", 10'(req_ready), 10'd1);
        pix(12, 14, "same_new_pix");
    endtask

    task automatic test_edge();
        int bad = 0;
        do_req(1020, 0, 1, 1);
        pulse_frame();
        m_x = 1020; m_y = 0; m_idx = 1; m_show = 1;
        for (int x = 1020; x < 1024; x++) begin
            pix(x, 0, "edge_row0");
            pix(x, 15, "edge_row15");
        end
        pix(1020, 16, "edge_row16");
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 12; x++) begin
                DrawX = 10'(x);
                DrawY = 10'(y);
                @(posedge Clk); @(posedge Clk); #1;
                checks++;
                if (pix_opaque !== 1'b0) begin
                    failures++;
                    if (bad < 5)
                        $display("FAIL edge_nowrap (%0d,%0d): opaque=%b required 0", x, y, pix_opaque);
                    bad++;
                end
            end
    endtask

    task automatic test_reset_pend();
        do_req(50, 50, 4, 1);
        chk("rp_pending", 10'(req_ready), 10'd0);
        Reset_n = 1'b0;
        #1;
        chk("rp_ready", 10'(req_ready), 10'd1);
        chk("rp_index", 10'(sprite_index), 10'd0);
        chk("rp_opaque", 10'(pix_opaque), 10'd0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        m_x = 0; m_y = 0; m_idx = 0; m_show = 0;
        pulse_frame();
        chk("rp_no_commit", 10'(sprite_index), 10'd0);
        chk("rp_ready_after", 10'(req_ready), 10'd1);
        pix(55, 55, "rp_pix_pending_pos");
        pix(5, 1, "rp_pix_origin");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_same_cycle();
        test_edge();
        test_reset_pend();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
